scariv_br_redirect_ctrl: RTL
============================

SCARIV_BR_REDIRECT_CTRL -- requirements
Module: scariv_br_redirect_ctrl

Interface
REQ-001 SHALL have parameter BRU_NUM, default 2, meaning number of branch-update sources.
REQ-002 SHALL have parameter CMT_ID_W, default 6, meaning commit-ID width; the MSB is the wrap bit.
REQ-003 SHALL have parameter GRP_W, default 4, meaning one-hot group-ID width.
REQ-004 SHALL have parameter VADDR_W, default 39, meaning redirect address width.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port i_upd_valid, input, BRU_NUM, meaning the per-source branch-update strobe.
REQ-008 SHALL have port i_upd_mispredict, input, BRU_NUM, meaning the resolved branch mispredicted.
REQ-009 SHALL have port i_upd_dead, input, BRU_NUM, meaning the update belongs to an already-flushed instruction.
REQ-010 SHALL have ports i_upd_cmt_id [BRU_NUM][CMT_ID_W], i_upd_grp_id [BRU_NUM][GRP_W] and i_upd_target_vaddr [BRU_NUM][VADDR_W], all inputs.
REQ-011 SHALL have port i_commit_flush, input, 1, meaning a commit-stage exception/flush.
REQ-012 SHALL have ports o_redirect_valid (output, 1), o_redirect_vaddr (output, VADDR_W) and i_redirect_ready (input, 1), forming the frontend redirect handshake.
REQ-013 SHALL have ports o_kill_valid (output, 1), o_kill_cmt_id (output, CMT_ID_W) and o_kill_grp_id (output, GRP_W), forming the younger-than-branch kill broadcast.
REQ-014 SHALL have port o_mispred_cnt, output, 16, meaning the accepted-redirect counter.

Function
REQ-015 SHALL treat an update as a candidate only when valid & mispredict & ~dead.
REQ-016 SHALL define age ordering: A is older than B when cmt_id wrap bits are equal and A.idx < B.idx, or wrap bits differ and A.idx > B.idx; for equal cmt_id, A is older when A's set grp bit is lower.
REQ-017 SHALL select the oldest candidate among the BRU_NUM sources; for identical cmt_id/grp_id, the lowest source index wins.
REQ-018 SHALL use the states IDLE and PEND.
REQ-019 SHALL, in IDLE, capture a winning candidate in cycle N and enter PEND, asserting o_redirect_valid in cycle N+1 (latency 1, registered).
REQ-020 SHALL, in PEND, replace the held entry when the winning candidate is strictly older than it; equal or younger candidates are dropped.
REQ-021 SHALL keep o_redirect_vaddr stable while in PEND, except on a replacement per REQ-020.
REQ-022 SHALL, on valid & ready, count the handshake as accepted and return to IDLE, unless an older candidate arrives in the same cycle.
REQ-023 SHALL, when acceptance and a candidate coincide, compare the candidate with the entry being accepted: if older, capture it and stay in PEND; otherwise drop it.
REQ-024 SHALL pulse o_kill_valid for exactly one cycle (N+1) on every capture or replacement, carrying the captured cmt_id/grp_id.
REQ-025 SHALL give i_commit_flush priority over all updates: it clears the held entry and forces IDLE next cycle, with o_redirect_valid=0 and no kill pulse for same-cycle candidates.
REQ-026 SHALL increment o_mispred_cnt by 1 per accepted handshake, saturating at 16'hFFFF.
REQ-027 SHALL handle cmt_id wrap per REQ-016, including comparisons between entries whose indices straddle wrap.

Reset
REQ-028 SHALL, when i_reset_n=0 at a clock edge, enter IDLE with o_redirect_valid=0, o_kill_valid=0, o_redirect_vaddr=0, o_kill_cmt_id=0, o_kill_grp_id=0 and o_mispred_cnt=0.
REQ-029 SHALL, on reset asserted mid-PEND, discard the pending entry without completing a handshake.
REQ-030 SHALL NOT let any output change between clock edges because of reset, since reset is sampled only at the clock.

Verification
REQ-031 SHALL cover a single mispredict: source0 cmt=5, grp=0001, tgt=0x1000, ready=1 -> valid/kill in the next cycle with vaddr 0x1000 and kill cmt 5, then IDLE, cnt=1.
REQ-032 SHALL cover simultaneous sources: src0 cmt=7/grp0010 and src1 cmt=7/grp0001 -> src1 wins, kill grp=0001.
REQ-033 SHALL cover backpressure replacement: pending cmt=10, ready=0, new cmt=8 -> vaddr switches to cmt 8's target, second kill pulse; a subsequent cmt=12 is ignored.
REQ-034 SHALL cover wrap: pending cmt=6'b1_00010, candidate cmt=6'b0_11110 -> the candidate is older and replaces the pending entry.
REQ-035 SHALL cover flush priority: PEND plus i_commit_flush=1 together with an older candidate -> next cycle valid=0, kill=0, cnt unchanged.
REQ-036 SHALL cover dead filtering and saturation: a dead mispredict produces no response; with cnt preloaded to 0xFFFF via 65535 accepts, one more accept leaves cnt=0xFFFF.

Source files
------------

// File: rtl/scariv_br_redirect_ctrl.sv
// Branch-mispredict redirect arbiter: keeps the oldest mispredicted branch pending toward the
// frontend and broadcasts a one-cycle kill for everything younger than each newly captured branch.
module scariv_br_redirect_ctrl #(
  parameter int BRU_NUM  = 2,
  parameter int CMT_ID_W = 6,
  parameter int GRP_W    = 4,
  parameter int VADDR_W  = 39
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [BRU_NUM-1:0]  i_upd_valid,
  input  logic [BRU_NUM-1:0]  i_upd_mispredict,
  input  logic [BRU_NUM-1:0]  i_upd_dead,
  input  logic [CMT_ID_W-1:0] i_upd_cmt_id       [BRU_NUM],
  input  logic [GRP_W-1:0]    i_upd_grp_id       [BRU_NUM],
  input  logic [VADDR_W-1:0]  i_upd_target_vaddr [BRU_NUM],
  input  logic                i_commit_flush,
  output logic                o_redirect_valid,
  output logic [VADDR_W-1:0]  o_redirect_vaddr,
  input  logic                i_redirect_ready,
  output logic                o_kill_valid,
  output logic [CMT_ID_W-1:0] o_kill_cmt_id,
  output logic [GRP_W-1:0]    o_kill_grp_id,
  output logic [15:0]         o_mispred_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]          state;
  logic                win_vld;
  logic [CMT_ID_W-1:0] win_cmt;
  logic [GRP_W-1:0]    win_grp;
  logic [VADDR_W-1:0]  win_vaddr;
  logic                accept;
  logic                capture;

  // The MSB of cmt_id flips each time the ROB index wraps, so differing wrap bits reverse the index order.
  // Grp IDs are one-hot, so a plain numeric compare orders them by set-bit position.
  function automatic logic is_older(input logic [CMT_ID_W-1:0] a_cmt, input logic [GRP_W-1:0] a_grp,
                                    input logic [CMT_ID_W-1:0] b_cmt, input logic [GRP_W-1:0] b_grp);
    if (a_cmt == b_cmt)
      return a_grp < b_grp;
    else if (a_cmt[CMT_ID_W-1] == b_cmt[CMT_ID_W-1])
      return a_cmt[CMT_ID_W-2:0] < b_cmt[CMT_ID_W-2:0];
    else
      return a_cmt[CMT_ID_W-2:0] > b_cmt[CMT_ID_W-2:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Only a strictly older source displaces the current winner, so ties go to the lowest index.
  always_comb begin
    win_vld   = 1'b0;
    win_cmt   = '0;
    win_grp   = '0;
    win_vaddr = '0;
    for (int i = 0; i < BRU_NUM; i++) begin
      if (i_upd_valid[i] && i_upd_mispredict[i] && !i_upd_dead[i] &&
          (!win_vld || is_older(i_upd_cmt_id[i], i_upd_grp_id[i], win_cmt, win_grp))) begin
        win_vld   = 1'b1;
        win_cmt   = i_upd_cmt_id[i];
        win_grp   = i_upd_grp_id[i];
        win_vaddr = i_upd_target_vaddr[i];
      end
    end
  end

  // The kill ID registers double as the held entry's age key.
  assign accept  = (state == PEND) && i_redirect_ready;
  assign capture = win_vld && ((state == IDLE) || is_older(win_cmt, win_grp, o_kill_cmt_id, o_kill_grp_id));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state            <= IDLE;
      o_kill_valid     <= 1'b0;
      o_redirect_vaddr <= '0;
      o_kill_cmt_id    <= '0;
      o_kill_grp_id    <= '0;
      o_mispred_cnt    <= '0;
    end else begin
      o_kill_valid <= 1'b0;
      if (i_commit_flush) begin
        state <= IDLE;
      end else begin
        if (accept)
          o_mispred_cnt <= sat_inc(o_mispred_cnt);
        if (capture) begin
          state            <= PEND;
          o_redirect_vaddr <= win_vaddr;
          o_kill_valid     <= 1'b1;
          o_kill_cmt_id    <= win_cmt;
          o_kill_grp_id    <= win_grp;
        end else if (accept) begin
          state <= IDLE;
        end
      end
    end
  end

  assign o_redirect_valid = (state == PEND);

endmodule
